// File: rtl/port_pattern_pkg.sv
// Shared types and constants for the test-pattern port sequencer.
// Optional feature macro: PORT_PATTERN_LFSR_EN (mode 11 becomes an 8-bit Galois LFSR).
package port_pattern_pkg;

  // Pattern mode, encoded as on the mode input.
  typedef enum logic [1:0] {
    MODE_COUNT     = 2'b00,
    MODE_WALK      = 2'b01,
    MODE_TOGGLE    = 2'b10,
    MODE_HOLD_LFSR = 2'b11
  } mode_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Feedback mask for x^8+x^6+x^5+x^4+1, right-shifting Galois form.
  localparam logic [7:0] LFSR_MASK = 8'hB8;

endpackage

// File: rtl/port_pattern_tick.sv
// Prescaler: counts 0..divider while enabled and flags the cycle in which the
// count equals divider (one tick every divider+1 enabled cycles).
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   clear         forces the count to 0 (has priority over enable)
//   enable        advance the count
//   divider       terminal count (0 = tick every enabled cycle)
//   tick_c        combinational tick, high for one cycle at terminal count
module port_pattern_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] divider,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  assign tick_c = enable && (cnt == divider);

  // Free count that wraps to 0 on each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == divider) cnt <= '0;
      else                cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/port_pattern_ctrl.sv
// Burst sequencer for the test-pattern port: start/abort handshake, prescaled
// advance, selectable pattern mode, fixed burst length, update strobe.
// Optional feature macro: PORT_PATTERN_LFSR_EN (mode 11 = LFSR instead of HOLD;
// requires WIDTH == 8).
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   start        begin a burst (sampled in IDLE only)
//   abort        end a burst without done (sampled in RUN only)
//   mode         00 COUNT, 01 WALK, 10 TOGGLE, 11 HOLD/LFSR
//   divider      cycles between advances minus one
//   length       advances per burst
//   seed         port value loaded at start
//   port         registered pattern output
//   strobe       one-cycle pulse with each new port value
//   busy         high while running
//   done         one-cycle pulse at burst completion
module port_pattern_ctrl
  import port_pattern_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] divider,
  input  logic [LEN_W-1:0] length,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] port,
  output logic             strobe,
  output logic             busy,
  output logic             done
);

`ifdef PORT_PATTERN_LFSR_EN
  if (WIDTH != 8) begin : g_lfsr_width_chk
    $error("port_pattern_ctrl: LFSR mode requires WIDTH == 8");
  end
`endif

  state_e           state_q, state_d;
  mode_e            mode_sh, mode_d;
  logic [DIV_W-1:0] div_sh, div_d;
  logic [LEN_W-1:0] len_sh, len_d;
  logic [LEN_W-1:0] step_q, step_d;
  logic [LEN_W-1:0] step_inc;
  logic [WIDTH-1:0] port_d, load_val, next_val;
  logic             strobe_d, busy_d, done_d;
  logic             tick_c;

  port_pattern_tick #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != ST_RUN),
    .enable (state_q == ST_RUN),
    .divider(div_sh),
    .tick_c (tick_c)
  );

  assign step_inc = step_q + LEN_W'(1);

  // Next pattern value for the latched mode.
  always_comb begin
    next_val = port;
    case (mode_sh)
      MODE_COUNT:  next_val = port + WIDTH'(1);
      MODE_WALK:   next_val = (port == '0) ? WIDTH'(1) : {port[WIDTH-2:0], port[WIDTH-1]};
      MODE_TOGGLE: next_val = ~port;
`ifdef PORT_PATTERN_LFSR_EN
      MODE_HOLD_LFSR: next_val = (port >> 1) ^ (port[0] ? WIDTH'(LFSR_MASK) : '0);
`else
      MODE_HOLD_LFSR: next_val = port;
`endif
      default:     next_val = port;
    endcase
  end

  // Seed as loaded at start; an all-zero LFSR seed would lock up.
  always_comb begin
    load_val = seed;
`ifdef PORT_PATTERN_LFSR_EN
    if ((mode_e'(mode) == MODE_HOLD_LFSR) && (seed == '0)) load_val = WIDTH'(1);
`endif
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_sh;
    div_d    = div_sh;
    len_d    = len_sh;
    step_d   = step_q;
    port_d   = port;
    strobe_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          div_d   = divider;
          len_d   = length;
          step_d  = '0;
          port_d  = load_val;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (abort) begin
          // Abort beats a coincident tick.
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (len_sh == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (tick_c) begin
          port_d   = next_val;
          strobe_d = 1'b1;
          step_d   = step_inc;
          if (step_inc == len_sh) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Shadow, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_sh <= MODE_COUNT;
      div_sh  <= '0;
      len_sh  <= '0;
      step_q  <= '0;
      port    <= '0;
      strobe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      mode_sh <= mode_d;
      div_sh  <= div_d;
      len_sh  <= len_d;
      step_q  <= step_d;
      port    <= port_d;
      strobe  <= strobe_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_port_pattern_ctrl.sv
// Self-checking bench for port_pattern_ctrl: directed table of bursts, a
// randomized burst loop, and an asynchronous-reset sequence. Expected outputs
// come from a closed-form timeline of each burst.
module tb_port_pattern_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [1:0]  mode;
  logic [15:0] divider, length;
  logic [7:0]  seed;
  logic [7:0]  port;
  logic        strobe, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  port_pattern_ctrl #(.WIDTH(8), .DIV_W(16), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .divider(divider), .length(length), .seed(seed),
    .port(port), .strobe(strobe), .busy(busy), .done(done)
  );

  typedef struct {
    logic [1:0]  m;
    logic [15:0] div;
    logic [15:0] len;
    logic [7:0]  sd;
    int          abort_at;   // RUN edge index carrying abort, 0 = none
    logic [7:0]  exp_port;
    int          exp_strobes;
    bit          exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] step_val(input logic [1:0] m, input logic [7:0] p);
    case (m)
      2'd0: return 8'((int'(p) + 1) % 256);
      2'd1: return (p == 8'd0) ? 8'h01 : 8'(((int'(p) * 2) % 256) + (int'(p) / 128));
      2'd2: return 8'(255 - int'(p));
`ifdef PORT_PATTERN_LFSR_EN
      default: return 8'((int'(p) / 2) ^ ((int'(p) % 2 == 1) ? 'hB8 : 0));
`else
      default: return p;
`endif
    endcase
  endfunction

  function automatic logic [7:0] after_n(input logic [1:0] m, input logic [7:0] s, input int n);
    logic [7:0] v = s;
    for (int i = 0; i < n; i++) v = step_val(m, v);
    return v;
  endfunction

  function automatic int unsigned pack_out(input logic [7:0] p, input bit s, input bit b, input bit d);
    return {21'd0, p, s, b, d};
  endfunction

  // One burst: start edge, scrambled inputs during the run, expected outputs
  // checked after every edge through the return to IDLE.
  task automatic run_burst(input logic [1:0] m, input logic [15:0] div, input logic [15:0] len,
                           input logic [7:0] sd, input int abort_at, input string tag,
                           output logic [7:0] fin, output int strobes, output bit done_seen);
    logic [7:0]  s0;
    int          d1, total, last, a;
    int unsigned exp;
    s0 = sd;
`ifdef PORT_PATTERN_LFSR_EN
    if (m == 2'd3 && sd == 8'd0) s0 = 8'h01;
`endif
    d1 = int'(div) + 1;
    total = int'(len) * d1;
    last = (abort_at != 0) ? abort_at : ((len == 16'd0) ? 1 : total);
    strobes = 0;
    done_seen = 1'b0;
    start = 1'b1; abort = 1'b0; mode = m; divider = div; length = len; seed = sd;
    @(posedge clk); #1;
    check($sformatf("%s start", tag), pack_out(port, strobe, busy, done), pack_out(s0, 0, 1, 0));
    for (int j = 1; j <= last + 1; j++) begin
      start   = 1'($urandom_range(0, 1));
      mode    = 2'($urandom);
      divider = 16'($urandom_range(0, 3));
      length  = 16'($urandom_range(0, 6));
      seed    = 8'($urandom);
      abort   = (abort_at != 0) && (j == abort_at);
      if (abort_at != 0 && j == last + 1) start = 1'b0;
      @(posedge clk); #1;
      if (abort_at != 0 && j >= abort_at)
        exp = pack_out(after_n(m, s0, (abort_at - 1) / d1), 0, 0, 0);
      else if (len == 16'd0)
        exp = pack_out(s0, 0, 0, j == 1);
      else if (j <= total) begin
        a = j / d1;
        exp = pack_out(after_n(m, s0, a), (j % d1) == 0, j < total, j == total);
      end else
        exp = pack_out(after_n(m, s0, int'(len)), 0, 0, 0);
      check($sformatf("%s edge %0d", tag, j), pack_out(port, strobe, busy, done), exp);
      strobes += int'(strobe);
      done_seen |= done;
    end
    start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s idle", tag), pack_out(port, strobe, busy, done),
          pack_out(fin_port(m, s0, len, d1, abort_at), 0, 0, 0));
    fin = port;
  endtask

  function automatic logic [7:0] fin_port(input logic [1:0] m, input logic [7:0] s0,
                                          input logic [15:0] len, input int d1, input int abort_at);
    if (abort_at != 0) return after_n(m, s0, (abort_at - 1) / d1);
    return after_n(m, s0, int'(len));
  endfunction

  initial begin
    logic [7:0] fin;
    int         strobes, ab, tot;
    bit         dn;

    vecs[0] = '{2'd0, 16'd0, 16'd4, 8'hFE, 0, 8'h02, 4, 1'b1};
    vecs[1] = '{2'd1, 16'd2, 16'd3, 8'h00, 0, 8'h04, 3, 1'b1};
    vecs[2] = '{2'd2, 16'd1, 16'd8, 8'h5A, 7, 8'hA5, 3, 1'b0};
    vecs[3] = '{2'd0, 16'd2, 16'd0, 8'h33, 0, 8'h33, 0, 1'b1};
`ifdef PORT_PATTERN_LFSR_EN
    vecs[4] = '{2'd3, 16'd0, 16'd3, 8'h01, 0, 8'h2E, 3, 1'b1};
`else
    vecs[4] = '{2'd3, 16'd0, 16'd3, 8'h01, 0, 8'h01, 3, 1'b1};
`endif
    vecs[5] = '{2'd0, 16'd3, 16'd2, 8'hFF, 4, 8'hFF, 0, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
    divider = 16'd0; length = 16'd0; seed = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", pack_out(port, strobe, busy, done), pack_out(8'h00, 0, 0, 0));
    start = 1'b1;
    @(posedge clk); #1;
    check("start held in reset", pack_out(port, strobe, busy, done), pack_out(8'h00, 0, 0, 0));
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_burst(vecs[i].m, vecs[i].div, vecs[i].len, vecs[i].sd, vecs[i].abort_at,
                $sformatf("vec%0d", i), fin, strobes, dn);
      check($sformatf("vec%0d final port", i), fin, vecs[i].exp_port);
      check($sformatf("vec%0d strobes", i), strobes, vecs[i].exp_strobes);
      check($sformatf("vec%0d done", i), dn, vecs[i].exp_done);
    end

    // Asynchronous reset between edges while a burst is strobing every cycle.
    start = 1'b1; mode = 2'd0; divider = 16'd0; length = 16'd10; seed = 8'h10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre-reset strobe", strobe, 1);
    rst = 1'b1;
    #1;
    check("async reset", pack_out(port, strobe, busy, done), pack_out(8'h00, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset idle", pack_out(port, strobe, busy, done), pack_out(8'h00, 0, 0, 0));
    run_burst(2'd0, 16'd0, 16'd3, 8'h20, 0, "after rst", fin, strobes, dn);
    check("after rst final", fin, 8'h23);

    // Randomized bursts, some aborted (including on a tick edge).
    for (int r = 0; r < 40; r++) begin
      logic [15:0] dv, ln;
      dv = 16'($urandom_range(0, 3));
      ln = 16'($urandom_range(0, 6));
      tot = int'(ln) * (int'(dv) + 1);
      ab = (tot > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, tot)) : 0;
      run_burst(2'($urandom), dv, ln, 8'($urandom), ab, $sformatf("rnd%0d", r), fin, strobes, dn);
      check($sformatf("rnd%0d done flag", r), dn, (ab == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
